// File: rtl/xgemac_tx_arbiter.sv
// ---------------------------------------------------------------------------
// xgemac_tx_arbiter
//
// Packet-granular round-robin arbiter in front of the XGEMAC packet TX
// interface (clk_156m25 domain). Up to NUM_REQ sources compete for the MAC;
// once a source wins with a sop word it keeps the grant until its eop word
// has been accepted, so packets are never interleaved on pkt_tx_*.
//
// Malformed traffic is handled locally:
//   - a non-sop word presented while no packet is open is accepted and
//     discarded, and the source sees a one-cycle err_pulse;
//   - a sop word arriving inside an open packet closes that packet (sent as
//     an eop word with mod 0), raises err_pulse, and the new packet's first
//     word is lost.
//
// Ports
//   clk_156m25, reset_156m25_n   core clock, async active-low reset
//   arb_en                       allow new grants (open packet always finishes)
//   req_val/sop/eop/mod/data     per-requester word interface (packed lanes)
//   req_ready                    per-requester accept strobe (combinational)
//   pkt_tx_full                  MAC TX FIFO full; blocks every req_ready
//   pkt_tx_val/sop/eop/mod/data  registered word stream to the MAC
//   grant_id, busy               current owner and packet-open status
//   err_pulse                    one-cycle protocol error pulse per requester
//   tx_pkt_cnt                   wrapping count of eop words sent to the MAC
// ---------------------------------------------------------------------------
module xgemac_tx_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int CNT_W   = 16
) (
   input  logic                    clk_156m25,
   input  logic                    reset_156m25_n,
   input  logic                    arb_en,
   input  logic [NUM_REQ-1:0]      req_val,
   input  logic [NUM_REQ-1:0]      req_sop,
   input  logic [NUM_REQ-1:0]      req_eop,
   input  logic [NUM_REQ*3-1:0]    req_mod,
   input  logic [NUM_REQ*64-1:0]   req_data,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic                    pkt_tx_full,
   output logic                    pkt_tx_val,
   output logic                    pkt_tx_sop,
   output logic                    pkt_tx_eop,
   output logic [2:0]              pkt_tx_mod,
   output logic [63:0]             pkt_tx_data,
   output logic [2:0]              grant_id,
   output logic                    busy,
   output logic [NUM_REQ-1:0]      err_pulse,
   output logic [CNT_W-1:0]        tx_pkt_cnt
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PKT  = 1'b1
   } state_t;

   localparam logic [2:0] LAST_IDX = 3'(NUM_REQ - 1);

   state_t               r_state;
   logic [2:0]           r_ptr;
   logic [2:0]           r_grant;
   logic                 r_busy;
   logic                 r_txVal;
   logic                 r_txSop;
   logic                 r_txEop;
   logic [2:0]           r_txMod;
   logic [63:0]          r_txData;
   logic [NUM_REQ-1:0]   r_err;
   logic [CNT_W-1:0]     r_cnt;

   logic                 w_winValid;
   logic [2:0]           w_win;
   logic                 w_grantNew;
   logic [NUM_REQ-1:0]   w_drop;
   logic [NUM_REQ-1:0]   w_ready;
   logic [2:0]           w_sel;
   logic                 w_selVal;
   logic                 w_selSop;
   logic                 w_selEop;
   logic [2:0]           w_selMod;
   logic [63:0]          w_selData;
   logic                 w_acc;
   logic                 w_sopErr;
   logic                 w_outSop;
   logic                 w_outEop;
   logic [2:0]           w_outMod;
   logic [NUM_REQ-1:0]   w_errNext;

   // Round-robin successor of a requester index.
   function automatic logic [2:0] nextIdx(input logic [2:0] idx);
      return (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;
   endfunction

   // Round-robin search: the first requester at or after r_ptr (wrapping)
   // that presents a sop word. Single-word and multi-word packets are treated
   // the same here; the eop bit only matters once the word is accepted.
   always_comb begin
      w_winValid = 1'b0;
      w_win      = 3'd0;
      for (int k = 0; k < NUM_REQ; k++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_winValid && (i == (int'(r_ptr) + k) % NUM_REQ)
                && req_val[i] && req_sop[i]) begin
               w_winValid = 1'b1;
               w_win      = 3'(i);
            end
         end
      end
   end

   // Grant decision and the IDLE-state drop of stray non-sop words. Drops
   // ignore arb_en (a stray word must never block its source) but still
   // respect pkt_tx_full so no ready is ever raised while the MAC is full.
   always_comb begin
      w_grantNew = (r_state == ST_IDLE) && w_winValid && arb_en && !pkt_tx_full;
      w_drop     = '0;
      if ((r_state == ST_IDLE) && !pkt_tx_full) begin
         w_drop = req_val & ~req_sop;
      end
   end

   // Ready generation. In PKT only the owner may move; in IDLE the winner
   // and any dropped requesters are accepted in the same cycle. Ready is
   // forced low while reset is asserted so nothing is taken during reset.
   always_comb begin
      w_ready = '0;
      if (r_state == ST_IDLE) begin
         w_ready = w_drop;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grantNew && (3'(i) == w_win)) begin
               w_ready[i] = 1'b1;
            end
         end
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (3'(i) == r_grant) begin
               w_ready[i] = !pkt_tx_full;
            end
         end
      end
      req_ready = reset_156m25_n ? w_ready : '0;
   end

   // Lane mux for the requester whose word may reach the MAC this cycle:
   // the fresh winner in IDLE, the current owner in PKT.
   always_comb begin
      w_sel     = (r_state == ST_IDLE) ? w_win : r_grant;
      w_selVal  = 1'b0;
      w_selSop  = 1'b0;
      w_selEop  = 1'b0;
      w_selMod  = 3'd0;
      w_selData = 64'd0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (3'(i) == w_sel) begin
            w_selVal  = req_val[i];
            w_selSop  = req_sop[i];
            w_selEop  = req_eop[i];
            w_selMod  = req_mod[3*i +: 3];
            w_selData = req_data[64*i +: 64];
         end
      end
   end

   // Accept qualification and sop-in-packet repair. A sop seen while a
   // packet is open terminates that packet on the MAC side: the word goes
   // out as a plain eop word with all 8 bytes valid.
   always_comb begin
      if (r_state == ST_IDLE) begin
         w_acc = w_grantNew;
      end else begin
         w_acc = w_selVal && !pkt_tx_full;
      end
      w_sopErr  = (r_state == ST_PKT) && w_acc && w_selSop;
      w_outSop  = w_sopErr ? 1'b0 : w_selSop;
      w_outEop  = w_sopErr ? 1'b1 : w_selEop;
      w_outMod  = w_sopErr ? 3'd0 : w_selMod;
      w_errNext = w_drop;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_sopErr && (3'(i) == r_grant)) begin
            w_errNext[i] = 1'b1;
         end
      end
   end

   // Arbiter FSM with its registered outputs. The output word register
   // loads only on an accept; otherwise pkt_tx_val drops and the rest hold.
   // The packet counter steps on the same edge that presents an eop word,
   // so it is already updated while that word is on pkt_tx_*. The round-robin
   // pointer moves past the owner only when its packet closes.
   always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
      if (!reset_156m25_n) begin
         r_state  <= ST_IDLE;
         r_ptr    <= 3'd0;
         r_grant  <= 3'd0;
         r_busy   <= 1'b0;
         r_txVal  <= 1'b0;
         r_txSop  <= 1'b0;
         r_txEop  <= 1'b0;
         r_txMod  <= 3'd0;
         r_txData <= 64'd0;
         r_err    <= '0;
         r_cnt    <= '0;
      end else begin
         r_txVal <= w_acc;
         r_err   <= w_errNext;
         if (w_acc) begin
            r_txSop  <= w_outSop;
            r_txEop  <= w_outEop;
            r_txMod  <= w_outMod;
            r_txData <= w_selData;
            if (w_outEop) begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end
         case (r_state)
            ST_IDLE: begin
               if (w_grantNew) begin
                  if (w_selEop) begin
                     r_ptr <= nextIdx(w_win);
                  end else begin
                     r_state <= ST_PKT;
                     r_grant <= w_win;
                     r_busy  <= 1'b1;
                  end
               end
            end
            ST_PKT: begin
               if (w_acc && (w_selEop || w_selSop)) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_ptr   <= nextIdx(r_grant);
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign pkt_tx_val  = r_txVal;
   assign pkt_tx_sop  = r_txSop;
   assign pkt_tx_eop  = r_txEop;
   assign pkt_tx_mod  = r_txMod;
   assign pkt_tx_data = r_txData;
   assign grant_id    = r_grant;
   assign busy        = r_busy;
   assign err_pulse   = r_err;
   assign tx_pkt_cnt  = r_cnt;

endmodule

// File: tb/tb_xgemac_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_xgemac_tx_arbiter
//
// Bench for xgemac_tx_arbiter with two requesters. Each cycle is one table
// record: the requester inputs, the ready pattern expected before the clock
// edge, which requester's word should reach the MAC (and whether it must be
// rewritten as a forced eop), and the err/busy/grant values expected after
// the edge. Expected MAC words go into a queue when the stimulus is driven
// and are popped when pkt_tx_val is sampled. The reset-mid-packet case is a
// hand-written sequence.
// ---------------------------------------------------------------------------
module tb_xgemac_tx_arbiter;

   localparam int NUM_REQ = 2;
   localparam int CNT_W   = 16;

   logic                  clk_156m25;
   logic                  reset_156m25_n;
   logic                  arb_en;
   logic [NUM_REQ-1:0]    req_val;
   logic [NUM_REQ-1:0]    req_sop;
   logic [NUM_REQ-1:0]    req_eop;
   logic [NUM_REQ*3-1:0]  req_mod;
   logic [NUM_REQ*64-1:0] req_data;
   logic [NUM_REQ-1:0]    req_ready;
   logic                  pkt_tx_full;
   logic                  pkt_tx_val;
   logic                  pkt_tx_sop;
   logic                  pkt_tx_eop;
   logic [2:0]            pkt_tx_mod;
   logic [63:0]           pkt_tx_data;
   logic [2:0]            grant_id;
   logic                  busy;
   logic [NUM_REQ-1:0]    err_pulse;
   logic [CNT_W-1:0]      tx_pkt_cnt;

   typedef struct {
      logic [1:0] val;
      logic [1:0] sop;
      logic [1:0] eop;
      logic       full;
      logic       arbEn;
      logic [1:0] expReady;
      int         sendId;
      logic       forceEop;
      logic [1:0] expErr;
      logic       expBusy;
      logic [2:0] expGrant;
   } vec_t;

   typedef struct {
      logic        sop;
      logic        eop;
      logic [2:0]  mod;
      logic [63:0] data;
   } word_t;

   vec_t  vecs[$];
   word_t expQ[$];
   int    compared;
   int    failed;
   int    step;
   int    expCnt;

   xgemac_tx_arbiter #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) dut (
      .clk_156m25     (clk_156m25),
      .reset_156m25_n (reset_156m25_n),
      .arb_en         (arb_en),
      .req_val        (req_val),
      .req_sop        (req_sop),
      .req_eop        (req_eop),
      .req_mod        (req_mod),
      .req_data       (req_data),
      .req_ready      (req_ready),
      .pkt_tx_full    (pkt_tx_full),
      .pkt_tx_val     (pkt_tx_val),
      .pkt_tx_sop     (pkt_tx_sop),
      .pkt_tx_eop     (pkt_tx_eop),
      .pkt_tx_mod     (pkt_tx_mod),
      .pkt_tx_data    (pkt_tx_data),
      .grant_id       (grant_id),
      .busy           (busy),
      .err_pulse      (err_pulse),
      .tx_pkt_cnt     (tx_pkt_cnt)
   );

   // 156.25 MHz-ish free-running clock.
   initial clk_156m25 = 1'b0;
   always #5 clk_156m25 = ~clk_156m25;

   function automatic logic [63:0] dataFor(input int r, input int s);
      return {8'hD0, 24'(r), 32'(s)};
   endfunction

   function automatic logic [2:0] modFor(input int r, input int s);
      return 3'(s + 3 * r + 1);
   endfunction

   function automatic vec_t mk(input logic [1:0] val, input logic [1:0] sop,
                               input logic [1:0] eop, input logic full,
                               input logic arbEn, input logic [1:0] expReady,
                               input int sendId, input logic forceEop,
                               input logic [1:0] expErr, input logic expBusy,
                               input logic [2:0] expGrant);
      vec_t t;
      t.val      = val;
      t.sop      = sop;
      t.eop      = eop;
      t.full     = full;
      t.arbEn    = arbEn;
      t.expReady = expReady;
      t.sendId   = sendId;
      t.forceEop = forceEop;
      t.expErr   = expErr;
      t.expBusy  = expBusy;
      t.expGrant = expGrant;
      return t;
   endfunction

   // Single comparison with counting and a FAIL line on mismatch.
   task automatic checkOutput(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Drive one table record, check ready before the edge, queue the word
   // the MAC should see, then check the registered outputs after the edge.
   task automatic applyStimulus(input vec_t t);
      word_t w;
      word_t got;
      int    r;
      step++;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_data[64*i +: 64] = dataFor(i, step);
         req_mod[3*i +: 3]    = modFor(i, step);
      end
      req_val     = t.val;
      req_sop     = t.sop;
      req_eop     = t.eop;
      pkt_tx_full = t.full;
      arb_en      = t.arbEn;
      #3;
      checkOutput($sformatf("s%0d req_ready", step), 64'(req_ready), 64'(t.expReady));
      if (t.sendId != 0) begin
         r      = t.sendId - 1;
         w.sop  = t.forceEop ? 1'b0 : t.sop[r];
         w.eop  = t.forceEop ? 1'b1 : t.eop[r];
         w.mod  = t.forceEop ? 3'd0 : modFor(r, step);
         w.data = dataFor(r, step);
         expQ.push_back(w);
         if (w.eop) expCnt++;
      end
      @(posedge clk_156m25);
      #1;
      if (expQ.size() > 0) begin
         got = expQ.pop_front();
         checkOutput($sformatf("s%0d pkt_tx_val", step), 64'(pkt_tx_val), 64'd1);
         checkOutput($sformatf("s%0d pkt_tx_data", step), pkt_tx_data, got.data);
         checkOutput($sformatf("s%0d pkt_tx_sop/eop/mod", step),
                     64'({pkt_tx_sop, pkt_tx_eop, pkt_tx_mod}),
                     64'({got.sop, got.eop, got.mod}));
      end else begin
         checkOutput($sformatf("s%0d pkt_tx_val", step), 64'(pkt_tx_val), 64'd0);
      end
      checkOutput($sformatf("s%0d err_pulse", step), 64'(err_pulse), 64'(t.expErr));
      checkOutput($sformatf("s%0d busy", step), 64'(busy), 64'(t.expBusy));
      checkOutput($sformatf("s%0d tx_pkt_cnt", step), 64'(tx_pkt_cnt), 64'(expCnt));
      if (t.expBusy) begin
         checkOutput($sformatf("s%0d grant_id", step), 64'(grant_id), 64'(t.expGrant));
      end
   endtask

   // Every output must read zero while reset is held.
   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, " req_ready"}, 64'(req_ready), 64'd0);
      checkOutput({tag, " pkt_tx_val"}, 64'(pkt_tx_val), 64'd0);
      checkOutput({tag, " pkt_tx_sop/eop/mod"},
                  64'({pkt_tx_sop, pkt_tx_eop, pkt_tx_mod}), 64'd0);
      checkOutput({tag, " pkt_tx_data"}, pkt_tx_data, 64'd0);
      checkOutput({tag, " busy"}, 64'(busy), 64'd0);
      checkOutput({tag, " grant_id"}, 64'(grant_id), 64'd0);
      checkOutput({tag, " err_pulse"}, 64'(err_pulse), 64'd0);
      checkOutput({tag, " tx_pkt_cnt"}, 64'(tx_pkt_cnt), 64'd0);
   endtask

   initial begin
      compared       = 0;
      failed         = 0;
      step           = 0;
      expCnt         = 0;
      reset_156m25_n = 1'b0;
      arb_en         = 1'b1;
      req_val        = '0;
      req_sop        = '0;
      req_eop        = '0;
      req_mod        = '0;
      req_data       = '0;
      pkt_tx_full    = 1'b0;

      //            val    sop    eop    full  en    ready  id fe  err    bsy  gnt
      // Three-word packet from req0, no contention.
      vecs.push_back(mk(2'b01, 2'b01, 2'b00, 1'b0, 1'b1, 2'b01, 1, 0, 2'b00, 1, 0));
      vecs.push_back(mk(2'b01, 2'b00, 2'b00, 1'b0, 1'b1, 2'b01, 1, 0, 2'b00, 1, 0));
      vecs.push_back(mk(2'b01, 2'b00, 2'b01, 1'b0, 1'b1, 2'b01, 1, 0, 2'b00, 0, 0));
      vecs.push_back(mk(2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 0, 0, 2'b00, 0, 0));
      // Both requesters streaming two-word packets: pointer now at 1.
      vecs.push_back(mk(2'b11, 2'b11, 2'b00, 1'b0, 1'b1, 2'b10, 2, 0, 2'b00, 1, 1));
      vecs.push_back(mk(2'b11, 2'b01, 2'b10, 1'b0, 1'b1, 2'b10, 2, 0, 2'b00, 0, 1));
      vecs.push_back(mk(2'b11, 2'b11, 2'b00, 1'b0, 1'b1, 2'b01, 1, 0, 2'b00, 1, 0));
      vecs.push_back(mk(2'b11, 2'b10, 2'b01, 1'b0, 1'b1, 2'b01, 1, 0, 2'b00, 0, 0));
      vecs.push_back(mk(2'b11, 2'b11, 2'b00, 1'b0, 1'b1, 2'b10, 2, 0, 2'b00, 1, 1));
      vecs.push_back(mk(2'b11, 2'b01, 2'b10, 1'b0, 1'b1, 2'b10, 2, 0, 2'b00, 0, 1));
      // MAC full for five cycles in the middle of a req0 packet.
      vecs.push_back(mk(2'b01, 2'b01, 2'b00, 1'b0, 1'b1, 2'b01, 1, 0, 2'b00, 1, 0));
      for (int i = 0; i < 5; i++) begin
         vecs.push_back(mk(2'b01, 2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 0, 0, 2'b00, 1, 0));
      end
      vecs.push_back(mk(2'b01, 2'b00, 2'b00, 1'b0, 1'b1, 2'b01, 1, 0, 2'b00, 1, 0));
      vecs.push_back(mk(2'b01, 2'b00, 2'b01, 1'b0, 1'b1, 2'b01, 1, 0, 2'b00, 0, 0));
      // Stray non-sop words in IDLE: dropped, even with arb_en low, not when full.
      vecs.push_back(mk(2'b10, 2'b00, 2'b00, 1'b0, 1'b1, 2'b10, 0, 0, 2'b10, 0, 0));
      vecs.push_back(mk(2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 0, 0, 2'b00, 0, 0));
      vecs.push_back(mk(2'b10, 2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 0, 0, 2'b00, 0, 0));
      vecs.push_back(mk(2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 2'b10, 0, 0, 2'b10, 0, 0));
      vecs.push_back(mk(2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 0, 0, 2'b00, 0, 0));
      // Sop inside an open req0 packet, then the grant passes to req1.
      vecs.push_back(mk(2'b01, 2'b01, 2'b00, 1'b0, 1'b1, 2'b01, 1, 0, 2'b00, 1, 0));
      vecs.push_back(mk(2'b01, 2'b01, 2'b00, 1'b0, 1'b1, 2'b01, 1, 1, 2'b01, 0, 0));
      vecs.push_back(mk(2'b11, 2'b11, 2'b00, 1'b0, 1'b1, 2'b10, 2, 0, 2'b00, 1, 1));
      vecs.push_back(mk(2'b11, 2'b01, 2'b10, 1'b0, 1'b1, 2'b10, 2, 0, 2'b00, 0, 1));
      // Single-word packet, then a win and a drop in the same cycle;
      // arb_en low inside the packet must not stall it.
      vecs.push_back(mk(2'b01, 2'b01, 2'b01, 1'b0, 1'b1, 2'b01, 1, 0, 2'b00, 0, 0));
      vecs.push_back(mk(2'b11, 2'b01, 2'b00, 1'b0, 1'b1, 2'b11, 1, 0, 2'b10, 1, 0));
      vecs.push_back(mk(2'b01, 2'b00, 2'b01, 1'b0, 1'b0, 2'b01, 1, 0, 2'b00, 0, 0));
      vecs.push_back(mk(2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 0, 0, 2'b00, 0, 0));

      // Reset state.
      repeat (3) @(posedge clk_156m25);
      #1;
      checkResetOutputs("reset");
      @(negedge clk_156m25);
      reset_156m25_n = 1'b1;
      @(posedge clk_156m25);
      #1;

      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
      end

      // Reset in the middle of a req0 packet (pointer is at 1 here).
      applyStimulus(mk(2'b01, 2'b01, 2'b00, 1'b0, 1'b1, 2'b01, 1, 0, 2'b00, 1, 0));
      step++;
      req_val  = 2'b01;
      req_sop  = 2'b00;
      req_eop  = 2'b00;
      req_data = {dataFor(1, step), dataFor(0, step)};
      #2;
      reset_156m25_n = 1'b0;
      #1;
      checkResetOutputs("mid-packet reset");
      req_val = '0;
      expQ.delete();
      expCnt = 0;
      repeat (2) @(posedge clk_156m25);
      @(negedge clk_156m25);
      reset_156m25_n = 1'b1;
      @(posedge clk_156m25);
      #1;
      // Pointer restarted at 0: req0 wins a tie, then req1 alone.
      applyStimulus(mk(2'b11, 2'b11, 2'b11, 1'b0, 1'b1, 2'b01, 1, 0, 2'b00, 0, 0));
      applyStimulus(mk(2'b10, 2'b10, 2'b10, 1'b0, 1'b1, 2'b10, 2, 0, 2'b00, 0, 0));
      applyStimulus(mk(2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 0, 0, 2'b00, 0, 0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

endmodule
